// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding, fixed timing constants and a counter-sizing helper for the PLL supervisor.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        SETTLE    = 3'd0,
        WAIT_LOCK = 3'd1,
        LOCKED    = 3'd2,
        GATE      = 3'd3,
        FAULT     = 3'd4
    } pll_ctrl_state_e;

    localparam int GATE_CYCLES = 2;
    localparam int SYNC_STAGES = 2;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Lock-flag synchroniser plus hysteresis filter: lk_f follows the synced flag after LOCK_FILTER equal samples.
// Latency SYNC_STAGES + LOCK_FILTER cycles; no backpressure, clr holds everything at 0.
module pll_lock_filter
    import pll_ctrl_pkg::*;
#(
    parameter int LOCK_FILTER = 8
) (
    input  logic clk_ref_i,
    input  logic arst_ni,
    input  logic clr,
    input  logic lk_async,
    output logic lk_f
);

    localparam int RW = $clog2(LOCK_FILTER + 1);
    localparam logic [RW-1:0] RUN_LAST = RW'(LOCK_FILTER - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [RW-1:0]          run_q;
    logic                   lk_s;

    assign lk_s = sync_q[SYNC_STAGES-1];

    // run_q counts consecutive synced samples that disagree with lk_f; any agreeing sample restarts it
    always_ff @(posedge clk_ref_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sync_q <= '0;
            run_q  <= '0;
            lk_f   <= 1'b0;
        end else if (clr) begin
            sync_q <= '0;
            run_q  <= '0;
            lk_f   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], lk_async};
            if (lk_s == lk_f) begin
                run_q <= '0;
            end else if (run_q == RUN_LAST) begin
                lk_f  <= lk_s;
                run_q <= '0;
            end else begin
                run_q <= run_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pll_ctrl.sv
// PLL configuration/lock supervisor: gates the output clock, reprograms dividers, waits for filtered lock, retries.
// Handshake at N -> clk_en low from N+1, dividers from N+3; cfg_ready_o only in LOCKED/FAULT, requests stall otherwise.
module pll_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int REF_DIV_WIDTH = 4,
    parameter int FB_DIV_WIDTH  = 8,
    parameter int RST_REF_DIV   = 1,
    parameter int RST_FB_DIV    = 1,
    parameter int SETTLE_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int LOCK_FILTER   = 8,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                     arst_ni,
    input  logic                     clk_ref_i,
    input  logic [REF_DIV_WIDTH-1:0] cfg_ref_div_i,
    input  logic [FB_DIV_WIDTH-1:0]  cfg_fb_div_i,
    input  logic                     cfg_valid_i,
    output logic                     cfg_ready_o,
    output logic [REF_DIV_WIDTH-1:0] pll_ref_div_o,
    output logic [FB_DIV_WIDTH-1:0]  pll_fb_div_o,
    input  logic                     pll_locked_i,
    output logic                     clk_en_o,
    output logic                     locked_o,
    output logic                     busy_o,
    output logic                     error_o,
    output logic                     lock_lost_o,
    output logic [3:0]               retry_cnt_o
);

    localparam int CW = cnt_width(SETTLE_CYCLES, LOCK_TIMEOUT, GATE_CYCLES);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] GATE_LAST   = CW'(GATE_CYCLES - 1);
    localparam logic [3:0]    MAX_RETRY   = 4'(MAX_RETRIES);

    pll_ctrl_state_e          state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [3:0]               retry_q, retry_d;
    logic [REF_DIV_WIDTH-1:0] ref_div_q, req_ref_q;
    logic [FB_DIV_WIDTH-1:0]  fb_div_q, req_fb_q;
    logic                     capture, load_div, hs, lk_f, filt_clr;

    // Holding the filter clear for the whole of SETTLE makes lock monitoring start fresh on every attempt
    assign filt_clr = (state_q == SETTLE);

    pll_lock_filter #(
        .LOCK_FILTER(LOCK_FILTER)
    ) u_lock_filter (
        .clk_ref_i(clk_ref_i),
        .arst_ni  (arst_ni),
        .clr      (filt_clr),
        .lk_async (pll_locked_i),
        .lk_f     (lk_f)
    );

    assign cfg_ready_o   = (state_q == LOCKED) || (state_q == FAULT);
    assign hs            = cfg_valid_i && cfg_ready_o;
    assign clk_en_o      = (state_q == LOCKED);
    assign locked_o      = (state_q == LOCKED) && lk_f;
    assign lock_lost_o   = (state_q == LOCKED) && !lk_f;
    assign busy_o        = (state_q == GATE) || (state_q == SETTLE) || (state_q == WAIT_LOCK);
    assign error_o       = (state_q == FAULT);
    assign retry_cnt_o   = retry_q;
    assign pll_ref_div_o = ref_div_q;
    assign pll_fb_div_o  = fb_div_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        retry_d  = retry_q;
        capture  = 1'b0;
        load_div = 1'b0;
        case (state_q)
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                if (lk_f) begin
                    state_d = LOCKED;
                    cnt_d   = '0;
                    retry_d = '0;
                end else if (cnt_q == TMO_LAST) begin
                    cnt_d = '0;
                    if (retry_q < MAX_RETRY) begin
                        retry_d = retry_q + 4'd1;
                        state_d = SETTLE;
                    end else begin
                        state_d = FAULT;
                    end
                end
            end
            LOCKED: begin
                cnt_d = '0;
                if (hs) begin
                    state_d = GATE;
                    capture = 1'b1;
                end else if (!lk_f) begin
                    state_d = SETTLE;
                    retry_d = '0;
                end
            end
            FAULT: begin
                cnt_d = '0;
                if (hs) begin
                    state_d = GATE;
                    capture = 1'b1;
                    retry_d = '0;
                end
            end
            GATE: begin
                if (cnt_q == GATE_LAST) begin
                    state_d  = SETTLE;
                    cnt_d    = '0;
                    load_div = 1'b1;
                end
            end
            default: begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_ref_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q   <= SETTLE;
            cnt_q     <= '0;
            retry_q   <= '0;
            ref_div_q <= REF_DIV_WIDTH'(RST_REF_DIV);
            fb_div_q  <= FB_DIV_WIDTH'(RST_FB_DIV);
            req_ref_q <= '0;
            req_fb_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            if (capture) begin
                req_ref_q <= cfg_ref_div_i;
                req_fb_q  <= cfg_fb_div_i;
            end
            // Dividers move only once the downstream gate has had GATE_CYCLES to close
            if (load_div) begin
                ref_div_q <= req_ref_q;
                fb_div_q  <= req_fb_q;
            end
        end
    end

endmodule

// File: tb/tb_pll_ctrl.sv
// Scoreboard bench for pll_ctrl: stimulus queues expected events with cycle spacing, a negedge monitor checks them.
module tb_pll_ctrl;

    localparam int REF_PERIOD = 100;
    localparam int EV_RST = 0, EV_ACC = 1, EV_LOCK = 2, EV_LOST = 3, EV_RETRY = 4, EV_FAULT = 5, EV_CLR = 6;

    typedef struct {
        int kind;
        int val;
        int delta;
    } exp_t;

    logic       arst_ni, clk_ref_i;
    logic [3:0] cfg_ref_div_i;
    logic [7:0] cfg_fb_div_i;
    logic       cfg_valid_i, cfg_ready_o;
    logic [3:0] pll_ref_div_o;
    logic [7:0] pll_fb_div_o;
    logic       pll_locked_i, clk_en_o, locked_o, busy_o, error_o, lock_lost_o;
    logic [3:0] retry_cnt_o;

    pll_ctrl #(
        .REF_DIV_WIDTH(4), .FB_DIV_WIDTH(8), .RST_REF_DIV(1), .RST_FB_DIV(1),
        .SETTLE_CYCLES(16), .LOCK_TIMEOUT(64), .LOCK_FILTER(8), .MAX_RETRIES(3)
    ) dut (
        .arst_ni(arst_ni), .clk_ref_i(clk_ref_i),
        .cfg_ref_div_i(cfg_ref_div_i), .cfg_fb_div_i(cfg_fb_div_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .pll_ref_div_o(pll_ref_div_o), .pll_fb_div_o(pll_fb_div_o),
        .pll_locked_i(pll_locked_i), .clk_en_o(clk_en_o), .locked_o(locked_o),
        .busy_o(busy_o), .error_o(error_o), .lock_lost_o(lock_lost_o),
        .retry_cnt_o(retry_cnt_o)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   edge_cnt = 0;
    int   last_stamp = 0;
    exp_t exp_q[$];

    initial begin
        clk_ref_i = 1'b0;
        forever #(REF_PERIOD / 2) clk_ref_i = ~clk_ref_i;
    end

    always @(posedge clk_ref_i) edge_cnt <= edge_cnt + 1;

    // Behavioural PLL: relocks 6 ref cycles after any divider change; output freq = ref * fb / ref_div
    logic       pll_lock_m = 1'b0;
    logic       force_low = 1'b0;
    logic       tie_low = 1'b0;
    int         lock_wait = 6;
    logic [3:0] last_ref = '0;
    logic [7:0] last_fb = '0;
    logic       pll_clk = 1'b0;
    int         pll_half = REF_PERIOD / 2;

    always @(negedge clk_ref_i) begin
        if (pll_ref_div_o !== last_ref || pll_fb_div_o !== last_fb) begin
            last_ref   <= pll_ref_div_o;
            last_fb    <= pll_fb_div_o;
            lock_wait  <= 6;
            pll_lock_m <= 1'b0;
        end else if (lock_wait > 0) begin
            lock_wait <= lock_wait - 1;
        end else begin
            pll_lock_m <= 1'b1;
        end
    end

    assign pll_locked_i = pll_lock_m & ~force_low & ~tie_low;

    always begin
        pll_half = (REF_PERIOD * ((last_ref == 0) ? 1 : int'(last_ref))) /
                   (2 * ((last_fb == 0) ? 1 : int'(last_fb)));
        if (pll_half < 1) pll_half = 1;
        #(pll_half) pll_clk = ~pll_clk;
    end

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic expect_ev(input int k, input int v, input int d);
        exp_t e;
        e.kind  = k;
        e.val   = v;
        e.delta = d;
        exp_q.push_back(e);
    endtask

    function automatic int lk_val(input int retry, input int r, input int f);
        return (retry << 12) | (r << 8) | f;
    endfunction

    task automatic check_ev(input int kind, input int val, input int stamp);
        exp_t e;
        int   d;
        n_cmp++;
        d = stamp - last_stamp;
        last_stamp = stamp;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL event: got kind=%0d val=%h at edge %0d with no event expected", kind, val, stamp);
        end else begin
            e = exp_q.pop_front();
            if (kind != e.kind || val != e.val || (e.delta >= 0 && d != e.delta)) begin
                n_err++;
                $display("FAIL event: got kind=%0d val=%h delta=%0d, expected kind=%0d val=%h delta=%0d",
                         kind, val, d, e.kind, e.val, e.delta);
            end
        end
    endtask

    logic       prev_err = 1'b0, prev_locked = 1'b0;
    logic [3:0] prev_retry = '0;

    always @(posedge arst_ni) check_ev(EV_RST, 0, edge_cnt);

    always @(negedge clk_ref_i) begin
        if (arst_ni) begin
            if (error_o != prev_err) check_ev(error_o ? EV_FAULT : EV_CLR, 0, edge_cnt);
            if (retry_cnt_o != prev_retry) check_ev(EV_RETRY, int'(retry_cnt_o), edge_cnt);
            if (lock_lost_o) check_ev(EV_LOST, 0, edge_cnt);
            if (locked_o && !prev_locked)
                check_ev(EV_LOCK, lk_val(retry_cnt_o, pll_ref_div_o, pll_fb_div_o), edge_cnt);
            if (cfg_valid_i && cfg_ready_o)
                check_ev(EV_ACC, lk_val(0, cfg_ref_div_i, cfg_fb_div_i), edge_cnt + 1);
        end
        prev_err    = error_o;
        prev_retry  = retry_cnt_o;
        prev_locked = locked_o;
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cfg_ready"}, int'(cfg_ready_o), 0);
        chk({tag, "_clk_en"}, int'(clk_en_o), 0);
        chk({tag, "_locked"}, int'(locked_o), 0);
        chk({tag, "_busy"}, int'(busy_o), 1);
        chk({tag, "_error"}, int'(error_o), 0);
        chk({tag, "_lock_lost"}, int'(lock_lost_o), 0);
        chk({tag, "_retry"}, int'(retry_cnt_o), 0);
        chk({tag, "_ref_div"}, int'(pll_ref_div_o), 1);
        chk({tag, "_fb_div"}, int'(pll_fb_div_o), 1);
    endtask

    task automatic wait_locked(input string name, input int limit);
        for (int i = 0; i < limit && !locked_o; i++) @(negedge clk_ref_i);
        chk(name, int'(locked_o), 1);
    endtask

    task automatic wait_accept(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_ref_i);
            if (cfg_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk_ref_i);
        #1 cfg_valid_i = 1'b0;
        chk(name, int'(ok), 1);
    endtask

    task automatic req(input string name, input logic [3:0] r, input logic [7:0] f);
        @(posedge clk_ref_i);
        #1;
        cfg_ref_div_i = r;
        cfg_fb_div_i  = f;
        cfg_valid_i   = 1'b1;
        wait_accept(name);
    endtask

    initial begin
        int t0, per;
        bit en_early;
        arst_ni       = 1'b0;
        cfg_valid_i   = 1'b0;
        cfg_ref_div_i = '0;
        cfg_fb_div_i  = '0;

        // Reset state, then release: SETTLE 16 + sync 2 + filter 8 + 1 -> locked 27 edges after release
        @(negedge clk_ref_i);
        check_reset_outputs("rst");
        expect_ev(EV_RST, 0, -1);
        expect_ev(EV_LOCK, lk_val(0, 1, 1), 27);
        @(posedge clk_ref_i);
        #1 arst_ni = 1'b1;
        en_early = 1'b0;
        for (int i = 0; i < 200 && !locked_o; i++) begin
            @(negedge clk_ref_i);
            if (clk_en_o && !locked_o) en_early = 1'b1;
        end
        chk("boot_locked", int'(locked_o), 1);
        chk("boot_clk_en_before_lock", int'(en_early), 0);
        chk("boot_clk_en", int'(clk_en_o), 1);
        chk("boot_error", int'(error_o), 0);

        // Reprogram 2/20 from LOCKED: gate closes next cycle, dividers two cycles later
        expect_ev(EV_ACC, lk_val(0, 2, 20), -1);
        expect_ev(EV_LOCK, lk_val(0, 2, 20), 29);
        req("acc_2_20", 4'd2, 8'd20);
        @(negedge clk_ref_i);
        chk("gate_clk_en_n1", int'(clk_en_o), 0);
        chk("gate_ref_div_n1", int'(pll_ref_div_o), 1);
        @(negedge clk_ref_i);
        chk("gate_fb_div_n2", int'(pll_fb_div_o), 1);
        @(negedge clk_ref_i);
        chk("gate_ref_div_n3", int'(pll_ref_div_o), 2);
        chk("gate_fb_div_n3", int'(pll_fb_div_o), 20);
        wait_locked("relock_2_20", 200);
        @(posedge pll_clk);
        t0 = $time;
        @(posedge pll_clk);
        per = $time - t0;
        chk("pll_period_x10", per, REF_PERIOD / 10);

        // 5-cycle dropout is filtered out
        @(posedge clk_ref_i);
        #1 force_low = 1'b1;
        repeat (5) @(posedge clk_ref_i);
        #1 force_low = 1'b0;
        repeat (20) @(negedge clk_ref_i);
        chk("glitch5_locked", int'(locked_o), 1);

        // 12-cycle dropout: one lock_lost pulse, SETTLE, relock
        expect_ev(EV_LOST, 0, -1);
        expect_ev(EV_LOCK, lk_val(0, 2, 20), 28);
        @(posedge clk_ref_i);
        #1 force_low = 1'b1;
        repeat (12) @(posedge clk_ref_i);
        #1 force_low = 1'b0;
        wait_locked("glitch12_relock", 200);

        // Request raised during WAIT_LOCK is held off and taken on the first LOCKED cycle
        expect_ev(EV_ACC, lk_val(0, 3, 30), -1);
        expect_ev(EV_LOCK, lk_val(0, 3, 30), 29);
        expect_ev(EV_ACC, lk_val(0, 5, 50), 1);
        expect_ev(EV_LOCK, lk_val(0, 5, 50), 29);
        req("acc_3_30", 4'd3, 8'd30);
        repeat (19) @(posedge clk_ref_i);
        #1;
        cfg_ref_div_i = 4'd5;
        cfg_fb_div_i  = 8'd50;
        cfg_valid_i   = 1'b1;
        @(negedge clk_ref_i);
        chk("hold_busy", int'(busy_o), 1);
        chk("hold_ready", int'(cfg_ready_o), 0);
        chk("hold_ref_div", int'(pll_ref_div_o), 3);
        chk("hold_fb_div", int'(pll_fb_div_o), 30);
        wait_accept("acc_5_50");
        wait_locked("relock_5_50", 200);

        // Lock never returns: three retries 80 cycles apart, then FAULT
        expect_ev(EV_LOST, 0, -1);
        expect_ev(EV_RETRY, 1, 81);
        expect_ev(EV_RETRY, 2, 80);
        expect_ev(EV_RETRY, 3, 80);
        expect_ev(EV_FAULT, 0, 80);
        @(posedge clk_ref_i);
        #1 tie_low = 1'b1;
        for (int i = 0; i < 1000 && !error_o; i++) @(negedge clk_ref_i);
        chk("fault_error", int'(error_o), 1);
        chk("fault_ready", int'(cfg_ready_o), 1);
        chk("fault_retry", int'(retry_cnt_o), 3);
        chk("fault_clk_en", int'(clk_en_o), 0);
        tie_low = 1'b0;
        expect_ev(EV_ACC, lk_val(0, 4, 40), -1);
        expect_ev(EV_CLR, 0, 0);
        expect_ev(EV_RETRY, 0, 0);
        expect_ev(EV_LOCK, lk_val(0, 4, 40), 29);
        req("acc_from_fault", 4'd4, 8'd40);
        wait_locked("relock_4_40", 200);

        // Async reset in the middle of GATE
        expect_ev(EV_ACC, lk_val(0, 6, 60), -1);
        req("acc_6_60", 4'd6, 8'd60);
        chk("gate_before_rst_busy", int'(busy_o), 1);
        arst_ni = 1'b0;
        #1;
        check_reset_outputs("midgate_rst");
        expect_ev(EV_RST, 0, -1);
        expect_ev(EV_LOCK, lk_val(0, 1, 1), 27);
        repeat (2) @(posedge clk_ref_i);
        #1 arst_ni = 1'b1;
        wait_locked("post_rst_lock", 200);

        repeat (5) @(negedge clk_ref_i);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
